keypad_word_assembler: RTL and testbench

//   Assembles keypad nibbles into a memory address and a multi-nibble data word.

---
 rtl/keypad_word_assembler.sv | 118 +++++++++++
 tb/tb_keypad_word_assembler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_word_assembler.sv
// Collects keypad nibbles into an address and a data word while the lock is open,
// then offers the finished word to a memory write port over a valid/ready handshake.
module keypad_word_assembler #(
  parameter int ADDR_NIBBLES = 1,
  parameter int DATA_NIBBLES = 2,
  parameter bit AUTO_INC     = 1'b1,
  localparam int CNT_W       = $clog2(DATA_NIBBLES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      on,
  input  logic                      o_unlock,
  input  logic                      en_key,
  input  logic [3:0]                key,
  input  logic                      addr_data,
  input  logic                      clr,
  input  logic                      commit,
  input  logic                      wr_ready,
  output logic                      wr_valid,
  output logic [4*ADDR_NIBBLES-1:0] addr_out,
  output logic [4*DATA_NIBBLES-1:0] data_out,
  output logic [CNT_W-1:0]          data_cnt,
  output logic                      overflow,
  output logic                      commit_err
);

  localparam int AW = 4 * ADDR_NIBBLES;
  localparam int DW = 4 * DATA_NIBBLES;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_NIBBLES);

  typedef enum logic {
    ENTRY    = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t        state;
  logic          data_full;
  logic [AW-1:0] addr_shifted;
  logic [DW-1:0] data_with_key;

  assign data_full = (data_cnt == FULL_CNT);

  // New address nibble enters at the bottom; the oldest one falls off the top.
  generate
    if (ADDR_NIBBLES == 1) begin : g_addr_one
      assign addr_shifted = key;
    end else begin : g_addr_multi
      assign addr_shifted = {addr_out[AW-5:0], key};
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < DATA_NIBBLES; gi++) begin : g_nibble
      assign data_with_key[4*gi +: 4] = (data_cnt == CNT_W'(gi)) ? key : data_out[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ENTRY;
      wr_valid   <= 1'b0;
      addr_out   <= '0;
      data_out   <= '0;
      data_cnt   <= '0;
      overflow   <= 1'b0;
      commit_err <= 1'b0;
    end else begin
      overflow   <= 1'b0;
      commit_err <= 1'b0;
      // Losing the unlock aborts any pending write but keeps the address.
      if (!o_unlock) begin
        state    <= ENTRY;
        wr_valid <= 1'b0;
        data_out <= '0;
        data_cnt <= '0;
      end else if (on) begin
        case (state)
          ENTRY: begin
            if (commit && data_full) begin
              state    <= WAIT_ACK;
              wr_valid <= 1'b1;
            end else begin
              if (commit) begin
                commit_err <= 1'b1;
              end
              if (clr) begin
                data_out <= '0;
                data_cnt <= '0;
              end else if (en_key) begin
                if (addr_data) begin
                  addr_out <= addr_shifted;
                end else if (data_full) begin
                  overflow <= 1'b1;
                end else begin
                  data_out <= data_with_key;
                  data_cnt <= data_cnt + 1'b1;
                end
              end
            end
          end
          WAIT_ACK: begin
            if (wr_ready) begin
              state    <= ENTRY;
              wr_valid <= 1'b0;
              data_out <= '0;
              data_cnt <= '0;
              if (AUTO_INC) begin
                addr_out <= addr_out + 1'b1;
              end
            end
          end
          default: state <= ENTRY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_word_assembler.sv
// Scoreboard bench: the driver runs a queue-based model and queues expectations;
// a monitor pops them after each clock edge and on every observed write handshake.
module tb_keypad_word_assembler;

  logic       clk = 1'b0;
  logic       rst, on, o_unlock, en_key, addr_data, clr, commit, wr_ready;
  logic [3:0] key;

  logic       wr_valid, overflow, commit_err;
  logic [3:0] addr_out;
  logic [7:0] data_out;
  logic [1:0] data_cnt;

  logic       wr_valid2, overflow2, commit_err2;
  logic [7:0] addr_out2;
  logic [7:0] data_out2;
  logic [1:0] data_cnt2;

  always #5 clk = ~clk;

  keypad_word_assembler #(.ADDR_NIBBLES(1), .DATA_NIBBLES(2), .AUTO_INC(1'b1)) dut (
    .clk(clk), .rst(rst), .on(on), .o_unlock(o_unlock), .en_key(en_key), .key(key),
    .addr_data(addr_data), .clr(clr), .commit(commit), .wr_ready(wr_ready),
    .wr_valid(wr_valid), .addr_out(addr_out), .data_out(data_out), .data_cnt(data_cnt),
    .overflow(overflow), .commit_err(commit_err)
  );

  keypad_word_assembler #(.ADDR_NIBBLES(2), .DATA_NIBBLES(2), .AUTO_INC(1'b1)) dut2 (
    .clk(clk), .rst(rst), .on(on), .o_unlock(o_unlock), .en_key(en_key), .key(key),
    .addr_data(addr_data), .clr(clr), .commit(commit), .wr_ready(wr_ready),
    .wr_valid(wr_valid2), .addr_out(addr_out2), .data_out(data_out2), .data_cnt(data_cnt2),
    .overflow(overflow2), .commit_err(commit_err2)
  );

  typedef struct packed {
    logic       wv;
    logic [3:0] a;
    logic [7:0] d;
    logic [1:0] c;
    logic       ov;
    logic       ce;
    logic [7:0] a2;
  } exp_t;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];

  // Reference model: data is a queue of entered nibbles, addresses are plain integers.
  int         m_addr, m_addr2;
  logic [3:0] m_data[$];
  bit         m_pend, m_ov, m_ce;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] data_val();
    logic [7:0] v;
    v = '0;
    foreach (m_data[i]) v = v | (8'(m_data[i]) << (4 * i));
    return v;
  endfunction

  task automatic drop_pending();
    if (m_pend && wr_q.size() > 0) wr_q.delete(wr_q.size() - 1);
    m_pend = 0;
  endtask

  // Apply one cycle of inputs, advance the model, queue expectations, wait a cycle.
  task automatic step(input bit r, input bit o, input bit u, input bit k, input logic [3:0] kv,
                      input bit ad, input bit cl, input bit cm, input bit rd);
    exp_t e;
    wr_t  w;
    rst = r; on = o; o_unlock = u; en_key = k; key = kv;
    addr_data = ad; clr = cl; commit = cm; wr_ready = rd;
    m_ov = 0;
    m_ce = 0;
    if (r) begin
      drop_pending();
      m_data.delete();
      m_addr  = 0;
      m_addr2 = 0;
    end else if (!u) begin
      drop_pending();
      m_data.delete();
    end else if (!o) begin
      // frozen
    end else if (m_pend) begin
      if (rd) begin
        m_pend  = 0;
        m_data.delete();
        m_addr  = (m_addr + 1) % 16;
        m_addr2 = (m_addr2 + 1) % 256;
      end
    end else if (cm && m_data.size() == 2) begin
      m_pend = 1;
      w.a = 4'(m_addr);
      w.d = data_val();
      wr_q.push_back(w);
    end else begin
      if (cm) m_ce = 1;
      if (cl) m_data.delete();
      else if (k) begin
        if (ad) begin
          m_addr  = (m_addr * 16 + kv) % 16;
          m_addr2 = (m_addr2 * 16 + kv) % 256;
        end else if (m_data.size() == 2) m_ov = 1;
        else m_data.push_back(kv);
      end
    end
    e.wv = m_pend;
    e.a  = 4'(m_addr);
    e.d  = data_val();
    e.c  = 2'(m_data.size());
    e.ov = m_ov;
    e.ce = m_ce;
    e.a2 = 8'(m_addr2);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input bit rd);
    step(0, 1, 1, 0, 4'h0, 0, 0, 0, rd);
  endtask

  task automatic press(input logic [3:0] kv, input bit ad);
    step(0, 1, 1, 1, kv, ad, 0, 0, 0);
  endtask

  // Monitor
  initial begin
    bit         pv;
    logic [3:0] pa;
    logic [7:0] pd;
    exp_t       e;
    wr_t        w;
    pv = 0;
    pa = '0;
    pd = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pv && wr_ready && on && o_unlock && !rst) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          w = wr_q.pop_front();
          chk("write_addr", pa, w.a);
          chk("write_data", pd, w.d);
        end
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_valid", wr_valid, e.wv);
        chk("addr_out", addr_out, e.a);
        chk("data_out", data_out, e.d);
        chk("data_cnt", data_cnt, e.c);
        chk("overflow", overflow, e.ov);
        chk("commit_err", commit_err, e.ce);
        chk("addr_out_2nib", addr_out2, e.a2);
        chk("wr_valid_2nib", wr_valid2, e.wv);
        chk("data_out_2nib", data_out2, e.d);
      end
      pv = wr_valid;
      pa = addr_out;
      pd = data_out;
    end
  end

  // Driver
  initial begin
    m_addr = 0; m_addr2 = 0; m_pend = 0; m_ov = 0; m_ce = 0;
    step(1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 4'h0, 0, 0, 0, 0);
    // data entry and overflow
    press(4'h3, 0); press(4'hA, 0); press(4'h7, 0); idle(0);
    // address, data, commit with held-off ready, then handshake
    step(0, 1, 1, 0, 4'h0, 0, 1, 0, 0);
    press(4'h5, 1); press(4'h1, 0); press(4'h2, 0);
    step(0, 1, 1, 0, 4'h0, 0, 0, 1, 0);
    idle(0); idle(0); idle(0); idle(1); idle(0);
    // address wrap from F
    press(4'hF, 1); press(4'h4, 0); press(4'h4, 0);
    step(0, 1, 1, 0, 4'h0, 0, 0, 1, 0); idle(1); idle(0);
    // incomplete commit with same-cycle clr and key
    press(4'h9, 0);
    step(0, 1, 1, 1, 4'h7, 0, 1, 1, 0); idle(0);
    // lock loss mid-handshake, keys ignored while locked
    press(4'h1, 0); press(4'h2, 0);
    step(0, 1, 1, 0, 4'h0, 0, 0, 1, 0); idle(0);
    step(0, 1, 0, 0, 4'h0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 4'h3, 0, 0, 0, 0);
    step(0, 1, 0, 1, 4'h3, 1, 0, 0, 0); idle(0);
    // two-nibble address shift, then reset while waiting for ack
    press(4'h1, 1); press(4'h2, 1); press(4'h3, 1);
    press(4'h5, 0); press(4'h6, 0);
    step(0, 1, 1, 0, 4'h0, 0, 0, 1, 0); idle(0);
    step(1, 1, 1, 0, 4'h0, 0, 0, 0, 1); idle(0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 39) != 0,
           $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0);
    end
    idle(0); idle(0);
    @(posedge clk);
    #2;
    chk("writes_outstanding", wr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
